// File: rtl/noc_output_arbiter_pkg.sv
// rtl/noc_output_arbiter_pkg.sv - shared NoC parameters and arbiter state encoding
package noc_output_arbiter_pkg;

    localparam int NOC_DATA_WIDTH = 32;
    localparam int NOC_NUM_IN     = 5;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/noc_rr_picker.sv
// rtl/noc_rr_picker.sv - combinational round-robin picker starting at rr_ptr
module noc_rr_picker #(
    parameter int NUM_IN = 5,
    parameter int IDX_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] elig,
    input  logic [IDX_W-1:0]  rr_ptr,
    output logic [IDX_W-1:0]  winner,
    output logic              any_valid
);

    // Scan from the farthest offset back to rr_ptr so the closest eligible index wins.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_IN) begin
                idx = idx - NUM_IN;
            end
            if (elig[idx]) begin
                winner    = IDX_W'(idx);
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// rtl/noc_output_arbiter.sv - wormhole round-robin output-port arbiter for one link
module noc_output_arbiter
    import noc_output_arbiter_pkg::*;
#(
    parameter int NUM_IN     = NOC_NUM_IN,
    parameter int DATA_WIDTH = NOC_DATA_WIDTH,
    parameter int IDX_W      = $clog2(NUM_IN)
) (
    input  logic                         noc_clk,
    input  logic                         noc_rst_n,
    input  logic [NUM_IN-1:0]            req_valid,
    output logic [NUM_IN-1:0]            req_ready,
    input  logic [NUM_IN*DATA_WIDTH-1:0] req_flit,
    input  logic [NUM_IN-1:0]            req_is_header,
    input  logic [NUM_IN-1:0]            req_is_tail,
    output logic                         sender_valid,
    input  logic                         sender_ready,
    output logic [DATA_WIDTH-1:0]        sender_flit,
    output logic                         sender_is_header,
    output logic                         sender_is_tail,
    output logic [IDX_W-1:0]             grant_id,
    output logic                         busy,
    output logic [15:0]                  pkt_count,
    output logic                         err_orphan
);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_id_q, grant_id_d;
    logic [15:0]      pkt_count_q, pkt_count_d;
    logic             err_orphan_q, err_orphan_d;

    logic [NUM_IN-1:0]     elig;
    logic [IDX_W-1:0]      winner;
    logic                  any_valid;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_active;
    logic                  sel_valid;
    logic                  sel_header;
    logic                  sel_tail;
    logic [DATA_WIDTH-1:0] sel_flit;
    logic                  xfer;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        if (idx == IDX_W'(NUM_IN - 1)) begin
            return '0;
        end
        return idx + IDX_W'(1);
    endfunction

    assign elig = req_valid & req_is_header;

    noc_rr_picker #(
        .NUM_IN (NUM_IN),
        .IDX_W  (IDX_W)
    ) u_picker (
        .elig      (elig),
        .rr_ptr    (rr_ptr_q),
        .winner    (winner),
        .any_valid (any_valid)
    );

    // Source selection: arbitration winner while idle, the locked owner otherwise.
    always_comb begin
        sel_idx    = grant_id_q;
        sel_active = 1'b1;
        if (state_q == ST_IDLE) begin
            sel_idx    = winner;
            sel_active = any_valid;
        end
    end

    // Mux the selected requester's flit and sideband flags.
    always_comb begin
        sel_valid  = 1'b0;
        sel_header = 1'b0;
        sel_tail   = 1'b0;
        sel_flit   = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (IDX_W'(i) == sel_idx) begin
                sel_valid  = req_valid[i];
                sel_header = req_is_header[i];
                sel_tail   = req_is_tail[i];
                sel_flit   = req_flit[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Link-facing outputs; everything combinational is held low while in reset.
    always_comb begin
        sender_valid     = 1'b0;
        sender_flit      = '0;
        sender_is_header = 1'b0;
        sender_is_tail   = 1'b0;
        req_ready        = '0;
        if (noc_rst_n && sel_active) begin
            sender_valid     = sel_valid;
            sender_flit      = sel_flit;
            sender_is_header = sel_header;
            sender_is_tail   = sel_tail;
            for (int i = 0; i < NUM_IN; i++) begin
                if (IDX_W'(i) == sel_idx) begin
                    req_ready[i] = sender_ready;
                end
            end
        end
    end

    assign xfer = sender_valid && sender_ready;

    // Next-state: lock on a multi-flit header, release and advance the pointer on tail.
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        pkt_count_d  = pkt_count_q;
        err_orphan_d = err_orphan_q;
        case (state_q)
            ST_IDLE: begin
                if (|(req_valid & ~req_is_header)) begin
                    err_orphan_d = 1'b1;
                end
                if (xfer) begin
                    grant_id_d = winner;
                    if (sel_tail) begin
                        rr_ptr_d    = next_idx(winner);
                        pkt_count_d = pkt_count_q + 16'd1;
                    end else begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (xfer && sel_tail) begin
                    state_d     = ST_IDLE;
                    rr_ptr_d    = next_idx(grant_id_q);
                    pkt_count_d = pkt_count_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            pkt_count_q  <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_id_q   <= grant_id_d;
            pkt_count_q  <= pkt_count_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign grant_id   = grant_id_q;
    assign busy       = (state_q == ST_LOCKED);
    assign pkt_count  = pkt_count_q;
    assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_noc_output_arbiter.sv
// tb/tb_noc_output_arbiter.sv - directed self-checking bench for noc_output_arbiter
module tb_noc_output_arbiter;
    import noc_output_arbiter_pkg::*;

    localparam int NI = 5;
    localparam int DW = NOC_DATA_WIDTH;
    localparam int IW = 3;

    logic              noc_clk;
    logic              noc_rst_n;
    logic [NI-1:0]     req_valid;
    logic [NI-1:0]     req_ready;
    logic [NI*DW-1:0]  req_flit;
    logic [NI-1:0]     req_is_header;
    logic [NI-1:0]     req_is_tail;
    logic              sender_valid;
    logic              sender_ready;
    logic [DW-1:0]     sender_flit;
    logic              sender_is_header;
    logic              sender_is_tail;
    logic [IW-1:0]     grant_id;
    logic              busy;
    logic [15:0]       pkt_count;
    logic              err_orphan;

    int n_cmp = 0;
    int n_err = 0;

    noc_output_arbiter dut (
        .noc_clk          (noc_clk),
        .noc_rst_n        (noc_rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_flit         (req_flit),
        .req_is_header    (req_is_header),
        .req_is_tail      (req_is_tail),
        .sender_valid     (sender_valid),
        .sender_ready     (sender_ready),
        .sender_flit      (sender_flit),
        .sender_is_header (sender_is_header),
        .sender_is_tail   (sender_is_tail),
        .grant_id         (grant_id),
        .busy             (busy),
        .pkt_count        (pkt_count),
        .err_orphan       (err_orphan)
    );

    initial noc_clk = 1'b0;
    always #5 noc_clk = ~noc_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] fv(input int i, input int k);
        return {16'hF0F0, 8'(i), 8'(k)};
    endfunction

    task automatic clr();
        req_valid     = '0;
        req_is_header = '0;
        req_is_tail   = '0;
        req_flit      = '0;
    endtask

    task automatic put(input int i, input logic h, input logic t, input logic [DW-1:0] f);
        req_valid[i]           = 1'b1;
        req_is_header[i]       = h;
        req_is_tail[i]         = t;
        req_flit[i*DW +: DW]   = f;
    endtask

    task automatic nxt();
        @(posedge noc_clk);
        #1;
    endtask

    initial begin
        logic       rdy [5];
        int         fidx [5];
        rdy  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        fidx = '{0, 1, 1, 1, 2};

        noc_rst_n    = 1'b0;
        sender_ready = 1'b1;
        clr();
        put(0, 1'b1, 1'b0, fv(0, 0));
        repeat (2) @(posedge noc_clk);
        #2;
        check_eq("rst_sender_valid", 32'(sender_valid), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_grant", 32'(grant_id), 32'd0);
        check_eq("rst_pkt", 32'(pkt_count), 32'd0);
        check_eq("rst_err", 32'(err_orphan), 32'd0);
        clr();
        noc_rst_n = 1'b1;

        // 4-flit packet on input 2
        nxt();
        clr();
        put(2, 1'b1, 1'b0, fv(2, 0));
        #1;
        check_eq("p2_h_valid", 32'(sender_valid), 32'd1);
        check_eq("p2_h_flit", 32'(sender_flit), 32'(fv(2, 0)));
        check_eq("p2_h_hdr", 32'(sender_is_header), 32'd1);
        check_eq("p2_h_ready", 32'(req_ready), 32'b00100);
        for (int k = 1; k < 4; k++) begin
            nxt();
            check_eq("p2_busy", 32'(busy), 32'd1);
            check_eq("p2_grant", 32'(grant_id), 32'd2);
            clr();
            put(2, 1'b0, (k == 3), fv(2, k));
            #1;
            check_eq("p2_flit", 32'(sender_flit), 32'(fv(2, k)));
            check_eq("p2_ready", 32'(req_ready), 32'b00100);
            check_eq("p2_tail", 32'(sender_is_tail), 32'(k == 3));
        end
        nxt();
        clr();
        check_eq("p2_done_busy", 32'(busy), 32'd0);
        check_eq("p2_done_pkt", 32'(pkt_count), 32'd1);

        // rr_ptr is now 3: between headers on 1 and 4, input 4 wins
        put(1, 1'b1, 1'b1, fv(1, 9));
        put(4, 1'b1, 1'b1, fv(4, 9));
        #1;
        check_eq("ptr3_ready", 32'(req_ready), 32'b10000);
        check_eq("ptr3_flit", 32'(sender_flit), 32'(fv(4, 9)));
        nxt();
        clr();
        check_eq("ptr3_grant", 32'(grant_id), 32'd4);
        check_eq("ptr3_pkt", 32'(pkt_count), 32'd2);

        // rr_ptr wrapped to 0: inputs 0 and 3 contend
        put(0, 1'b1, 1'b0, fv(0, 0));
        put(3, 1'b1, 1'b0, fv(3, 0));
        #1;
        check_eq("c03_ready_h", 32'(req_ready), 32'b00001);
        check_eq("c03_flit_h", 32'(sender_flit), 32'(fv(0, 0)));
        nxt();
        check_eq("c03_grant0", 32'(grant_id), 32'd0);
        clr();
        put(0, 1'b0, 1'b1, fv(0, 1));
        put(3, 1'b1, 1'b0, fv(3, 0));
        #1;
        check_eq("c03_ready_t", 32'(req_ready), 32'b00001);
        check_eq("c03_tail", 32'(sender_is_tail), 32'd1);
        nxt();
        check_eq("c03_idle", 32'(busy), 32'd0);
        clr();
        put(3, 1'b1, 1'b0, fv(3, 0));
        #1;
        check_eq("c03_ready3", 32'(req_ready), 32'b01000);
        nxt();
        check_eq("c03_grant3", 32'(grant_id), 32'd3);
        clr();
        put(3, 1'b0, 1'b1, fv(3, 1));
        #1;
        check_eq("c03_ready3_t", 32'(req_ready), 32'b01000);
        nxt();
        clr();
        check_eq("c03_pkt", 32'(pkt_count), 32'd4);

        // quick reset so fairness starts at rr_ptr 0 and pkt_count 0
        noc_rst_n = 1'b0;
        #2;
        noc_rst_n = 1'b1;
        check_eq("rst2_pkt", 32'(pkt_count), 32'd0);

        // Fairness: all inputs stream single-flit packets
        for (int k = 0; k < 10; k++) begin
            clr();
            for (int i = 0; i < NI; i++) begin
                put(i, 1'b1, 1'b1, fv(i, k));
            end
            #1;
            check_eq("fair_ready", 32'(req_ready), 32'(1 << (k % 5)));
            check_eq("fair_flit", 32'(sender_flit), 32'(fv(k % 5, k)));
            nxt();
            check_eq("fair_grant", 32'(grant_id), 32'(k % 5));
        end
        clr();
        check_eq("fair_pkt", 32'(pkt_count), 32'd10);

        // Backpressure during a locked 3-flit packet from input 1
        for (int c = 0; c < 5; c++) begin
            clr();
            put(1, (c == 0), (c == 4), fv(1, fidx[c]));
            put(2, 1'b1, 1'b0, fv(2, 0));
            sender_ready = rdy[c];
            #1;
            check_eq("bp_flit", 32'(sender_flit), 32'(fv(1, fidx[c])));
            check_eq("bp_ready", 32'(req_ready), rdy[c] ? 32'b00010 : 32'd0);
            nxt();
            check_eq("bp_busy", 32'(busy), 32'(c < 4));
        end
        clr();
        sender_ready = 1'b1;
        check_eq("bp_pkt", 32'(pkt_count), 32'd11);

        // Orphan body flit while idle
        put(1, 1'b0, 1'b0, fv(1, 5));
        #1;
        check_eq("orph_valid", 32'(sender_valid), 32'd0);
        check_eq("orph_ready", 32'(req_ready), 32'd0);
        nxt();
        clr();
        check_eq("orph_set", 32'(err_orphan), 32'd1);
        nxt();
        nxt();
        check_eq("orph_sticky", 32'(err_orphan), 32'd1);

        // Reset in the middle of a 4-flit packet from input 0
        put(0, 1'b1, 1'b0, fv(0, 0));
        nxt();
        clr();
        put(0, 1'b0, 1'b0, fv(0, 1));
        nxt();
        clr();
        put(0, 1'b0, 1'b0, fv(0, 2));
        #1;
        check_eq("mid_valid_pre", 32'(sender_valid), 32'd1);
        noc_rst_n = 1'b0;
        #1;
        check_eq("mid_valid_rst", 32'(sender_valid), 32'd0);
        check_eq("mid_ready_rst", 32'(req_ready), 32'd0);
        check_eq("mid_busy_rst", 32'(busy), 32'd0);
        nxt();
        noc_rst_n = 1'b1;
        clr();
        #1;
        check_eq("mid_pkt", 32'(pkt_count), 32'd0);
        check_eq("mid_err", 32'(err_orphan), 32'd0);
        check_eq("mid_busy", 32'(busy), 32'd0);
        put(4, 1'b1, 1'b0, fv(4, 0));
        #1;
        check_eq("mid_new_ready", 32'(req_ready), 32'b10000);
        check_eq("mid_new_valid", 32'(sender_valid), 32'd1);
        nxt();
        clr();
        check_eq("mid_new_busy", 32'(busy), 32'd1);
        check_eq("mid_new_grant", 32'(grant_id), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
